// File: rtl/blocking_cache_alt.sv
// Blocking write-back, write-allocate, 2-way set-associative data cache (4 B CPU port, 16 B line memory port).
// Latency: hit response 3 cycles after accept; a clean miss adds one memory round trip, a dirty miss adds two.
// Backpressure: one transaction in flight; cachereq_rdy only in IDLE; response and memory requests are held until accepted.
// Build option: define BLOCKING_CACHE_LRU_EN for per-set LRU replacement; otherwise a full set evicts the way named by tag bit 0.
module blocking_cache_alt #(
    parameter int NSETS = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [76:0]  cachereq_msg,
    input  logic         cachereq_val,
    output logic         cachereq_rdy,
    output logic [46:0]  cacheresp_msg,
    output logic         cacheresp_val,
    input  logic         cacheresp_rdy,
    output logic [174:0] memreq_msg,
    output logic         memreq_val,
    input  logic         memreq_rdy,
    input  logic [144:0] memresp_msg,
    input  logic         memresp_val,
    output logic         memresp_rdy
);
    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = 28 - IDXW;

    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_WRITE = 3'd1;
    localparam logic [2:0] T_INIT  = 3'd2;

    localparam logic [3:0] S_IDLE          = 4'd0;
    localparam logic [3:0] S_TAG_CHECK     = 4'd1;
    localparam logic [3:0] S_READ_ACC      = 4'd2;
    localparam logic [3:0] S_WRITE_ACC     = 4'd3;
    localparam logic [3:0] S_INIT_ACC      = 4'd4;
    localparam logic [3:0] S_EVICT_PREP    = 4'd5;
    localparam logic [3:0] S_EVICT_REQ     = 4'd6;
    localparam logic [3:0] S_EVICT_WAIT    = 4'd7;
    localparam logic [3:0] S_REFILL_REQ    = 4'd8;
    localparam logic [3:0] S_REFILL_WAIT   = 4'd9;
    localparam logic [3:0] S_REFILL_UPDATE = 4'd10;
    localparam logic [3:0] S_WAIT          = 4'd11;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4b_t;

    typedef struct packed {
        logic [2:0]  typ;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4b_t;

    typedef struct packed {
        logic [2:0]   typ;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16b_t;

    typedef struct packed {
        logic [2:0]   typ;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16b_t;

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    mem_req_4b_t      req_in;
    mem_req_4b_t      req;
    mem_resp_16b_t    mresp;
    mem_resp_4b_t     cresp;
    mem_req_16b_t     mreq;

    logic [NSETS-1:0] valid [2];
    logic [NSETS-1:0] dirty [2];
`ifdef BLOCKING_CACHE_LRU_EN
    logic [NSETS-1:0] lru;
`endif
    logic [TAGW-1:0]  tag_arr  [2][NSETS];
    logic [127:0]     line_arr [2][NSETS];

    logic             way_q;
    logic             hit_q;
    logic [31:0]      resp_data;
    logic [31:0]      evict_addr;
    logic [127:0]     evict_line;
    logic [127:0]     fill_line;

    logic [IDXW-1:0]  idx;
    logic [TAGW-1:0]  tag;
    logic [1:0]       word;
    logic             match0;
    logic             match1;
    logic             hit;
    logic             victim;
    logic             sel_way;
    logic             unused_bits;

    assign req_in = cachereq_msg;
    assign mresp  = memresp_msg;
    assign idx    = req.addr[4 +: IDXW];
    assign tag    = req.addr[31 -: TAGW];
    assign word   = req.addr[3:2];

    // Only the line payload of a memory response matters; header fields are ignored.
    assign unused_bits = ^{mresp.typ, mresp.opaque, mresp.test, mresp.len, req.addr[1:0]};

    // Hit detection and victim choice for the registered request.
    always_comb begin
        match0 = valid[0][idx] && (tag_arr[0][idx] == tag);
        match1 = valid[1][idx] && (tag_arr[1][idx] == tag);
        hit    = match0 | match1;
        if (!valid[0][idx])
            victim = 1'b0;
        else if (!valid[1][idx])
            victim = 1'b1;
        else
`ifdef BLOCKING_CACHE_LRU_EN
            victim = lru[idx];
`else
            victim = tag[0];
`endif
        // An INIT that hits rewrites the resident copy, so a tag never lives in both ways.
        sel_way = hit ? ~match0 : victim;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:          if (cachereq_val) state_nxt = S_TAG_CHECK;
            S_TAG_CHECK: begin
                if (req.typ == T_INIT)
                    state_nxt = S_INIT_ACC;
                else if (hit)
                    state_nxt = (req.typ == T_WRITE) ? S_WRITE_ACC : S_READ_ACC;
                else if (valid[victim][idx] && dirty[victim][idx])
                    state_nxt = S_EVICT_PREP;
                else
                    state_nxt = S_REFILL_REQ;
            end
            S_EVICT_PREP:    state_nxt = S_EVICT_REQ;
            S_EVICT_REQ:     if (memreq_rdy) state_nxt = S_EVICT_WAIT;
            S_EVICT_WAIT:    if (memresp_val) state_nxt = S_REFILL_REQ;
            S_REFILL_REQ:    if (memreq_rdy) state_nxt = S_REFILL_WAIT;
            S_REFILL_WAIT:   if (memresp_val) state_nxt = S_REFILL_UPDATE;
            S_REFILL_UPDATE: state_nxt = (req.typ == T_WRITE) ? S_WRITE_ACC : S_READ_ACC;
            S_READ_ACC,
            S_WRITE_ACC,
            S_INIT_ACC:      state_nxt = S_WAIT;
            S_WAIT:          if (cacheresp_rdy) state_nxt = S_IDLE;
            default:         state_nxt = S_IDLE;
        endcase
    end

    // State register and per-transaction datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            req        <= '0;
            way_q      <= 1'b0;
            hit_q      <= 1'b0;
            resp_data  <= '0;
            evict_addr <= '0;
            evict_line <= '0;
            fill_line  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && cachereq_val)
                req <= req_in;
            if (state == S_TAG_CHECK) begin
                way_q <= sel_way;
                hit_q <= hit && (req.typ != T_INIT);
            end
            if (state == S_EVICT_PREP) begin
                evict_addr <= {tag_arr[way_q][idx], idx, 4'h0};
                evict_line <= line_arr[way_q][idx];
            end
            if (state == S_REFILL_WAIT && memresp_val)
                fill_line <= mresp.data;
            if (state == S_READ_ACC)
                resp_data <= line_arr[way_q][idx][{word, 5'd0} +: 32];
            else if (state == S_WRITE_ACC || state == S_INIT_ACC)
                resp_data <= '0;
        end
    end

    // Line state bits: valid/dirty per way, plus replacement history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid[0] <= '0;
            valid[1] <= '0;
            dirty[0] <= '0;
            dirty[1] <= '0;
`ifdef BLOCKING_CACHE_LRU_EN
            lru      <= '0;
`endif
        end else begin
            case (state)
                S_REFILL_UPDATE,
                S_INIT_ACC: begin
                    valid[way_q][idx] <= 1'b1;
                    dirty[way_q][idx] <= 1'b0;
                end
                S_WRITE_ACC: dirty[way_q][idx] <= 1'b1;
                default: ;
            endcase
`ifdef BLOCKING_CACHE_LRU_EN
            // Every access stage follows a hit, refill or init, so it marks the other way as LRU.
            if (state == S_READ_ACC || state == S_WRITE_ACC || state == S_INIT_ACC)
                lru[idx] <= ~way_q;
`endif
        end
    end

    // Tag and line storage; contents are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == S_REFILL_UPDATE) begin
            tag_arr[way_q][idx]  <= tag;
            line_arr[way_q][idx] <= fill_line;
        end else if (state == S_WRITE_ACC) begin
            line_arr[way_q][idx][{word, 5'd0} +: 32] <= req.data;
        end else if (state == S_INIT_ACC) begin
            tag_arr[way_q][idx] <= tag;
            line_arr[way_q][idx][{word, 5'd0} +: 32] <= req.data;
        end
    end

    // Memory request: registered victim line during eviction, otherwise the refill read.
    always_comb begin
        mreq = '0;
        if (state == S_EVICT_REQ) begin
            mreq.typ  = T_WRITE;
            mreq.addr = evict_addr;
            mreq.data = evict_line;
        end else begin
            mreq.typ  = T_READ;
            mreq.addr = {tag, idx, 4'h0};
        end
    end

    assign cresp.typ     = req.typ;
    assign cresp.opaque  = req.opaque;
    assign cresp.test    = {1'b0, hit_q};
    assign cresp.len     = req.len;
    assign cresp.data    = resp_data;

    assign cachereq_rdy  = (state == S_IDLE) && reset;
    assign cacheresp_val = (state == S_WAIT);
    assign cacheresp_msg = cresp;
    assign memreq_val    = (state == S_EVICT_REQ) || (state == S_REFILL_REQ);
    assign memreq_msg    = mreq;
    assign memresp_rdy   = (state == S_EVICT_WAIT) || (state == S_REFILL_WAIT);

endmodule

// File: tb/tb_blocking_cache_alt.sv
// Self-checking bench for blocking_cache_alt: directed scenarios followed by random READ/WRITE traffic.
// The bench plays the memory side (with programmable stalls) and predicts responses and memory traffic
// from an architectural memory image plus a per-set residency model.
module tb_blocking_cache_alt;
    localparam int NSETS = 16;
    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_WRITE = 3'd1;
    localparam logic [2:0] T_INIT  = 3'd2;

    logic         clk = 1'b0;
    logic         reset;
    logic [76:0]  cachereq_msg;
    logic         cachereq_val;
    logic         cachereq_rdy;
    logic [46:0]  cacheresp_msg;
    logic         cacheresp_val;
    logic         cacheresp_rdy;
    logic [174:0] memreq_msg;
    logic         memreq_val;
    logic         memreq_rdy;
    logic [144:0] memresp_msg;
    logic         memresp_val;
    logic         memresp_rdy;

    int tests = 0;
    int fails = 0;

    logic [127:0] mem     [256];   // backing store as the cache sees it
    logic [127:0] ref_mem [256];   // architectural view (latest value of every word)
    bit           mv   [NSETS][2];
    bit           md   [NSETS][2];
    logic [23:0]  mt   [NSETS][2];
    bit           mlru [NSETS];
    logic [174:0] mrq_log [$];

    blocking_cache_alt #(.NSETS(NSETS)) dut (
        .clk(clk), .reset(reset),
        .cachereq_msg(cachereq_msg), .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
        .cacheresp_msg(cacheresp_msg), .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
        .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
        .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < NSETS; s++) begin
            mv[s][0] = 0; mv[s][1] = 0; md[s][0] = 0; md[s][1] = 0; mlru[s] = 0;
        end
    endtask

    function automatic bit pick_victim(int s, logic [23:0] t);
        if (!mv[s][0]) return 1'b0;
        if (!mv[s][1]) return 1'b1;
`ifdef BLOCKING_CACHE_LRU_EN
        return mlru[s];
`else
        return t[0];
`endif
    endfunction

    // Drive one request and act as memory until the response is taken.
    task automatic run_txn(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [7:0] opq, input int rs, input int ms,
                           output logic [46:0] resp, output int lat);
        int rs_cnt = 0, mq_cnt = 0, pend_cnt = 0;
        bit pending = 0, done = 0, busy_bad = 0, unstable = 0, mrdy_bad = 0;
        logic [46:0]  resp_first = '0;
        logic [174:0] mq_first = '0;
        logic [127:0] rd_line = '0;
        int ln;
        mrq_log.delete();
        lat  = -1;
        resp = '0;
        @(negedge clk);
        cachereq_msg = {typ, opq, addr, 2'd0, wdata};
        cachereq_val = 1'b1;
        for (int i = 0; i < 20 && cachereq_rdy !== 1'b1; i++) @(negedge clk);
        check("req_rdy_idle", cachereq_rdy, 1'b1);
        @(posedge clk);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            cachereq_val  = 1'b0;
            memreq_rdy    = 1'b0;
            memresp_val   = 1'b0;
            cacheresp_rdy = 1'b0;
            if (cachereq_rdy !== 1'b0) busy_bad = 1;
            if (memresp_rdy !== pending) mrdy_bad = 1;
            if (pending) begin
                if (pend_cnt >= ms) begin
                    memresp_val = 1'b1;
                    memresp_msg = {3'd0, 8'd0, 2'd0, 4'd0, rd_line};
                    pending = 0;
                end else pend_cnt++;
            end
            if (memreq_val) begin
                if (mq_cnt == 0) mq_first = memreq_msg;
                else if (memreq_msg !== mq_first) unstable = 1;
                if (mq_cnt >= ms) begin
                    memreq_rdy = 1'b1;
                    mrq_log.push_back(memreq_msg);
                    ln = int'(memreq_msg[143:136]);
                    if (memreq_msg[174:172] == T_WRITE) mem[ln] = memreq_msg[127:0];
                    rd_line  = mem[ln];
                    pending  = 1;
                    pend_cnt = 0;
                    mq_cnt   = 0;
                end else mq_cnt++;
            end
            if (cacheresp_val) begin
                if (lat < 0) begin
                    lat = cyc + 1;
                    resp_first = cacheresp_msg;
                end else if (cacheresp_msg !== resp_first) unstable = 1;
                if (rs_cnt >= rs) begin
                    cacheresp_rdy = 1'b1;
                    resp = cacheresp_msg;
                    done = 1;
                end else rs_cnt++;
            end
        end
        check("txn_done", done, 1'b1);
        check("busy_rdy_low", busy_bad, 1'b0);
        check("msg_stable", unstable, 1'b0);
        check("memresp_rdy", mrdy_bad, 1'b0);
        @(negedge clk);
        cacheresp_rdy = 1'b0;
        memreq_rdy    = 1'b0;
        memresp_val   = 1'b0;
        check("idle_after", cachereq_rdy, 1'b1);
    endtask

    // One architectural operation: predict, run, compare, then update the models.
    task automatic do_op(input logic [2:0] typ, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [7:0] opq, input int rs, input int ms, output logic [46:0] resp);
        int s, w, ln, lat, nexp;
        logic [23:0]  t;
        bit           hit, way, exp_ev, exp_rf, exp_test;
        logic [31:0]  ev_addr, exp_data;
        logic [127:0] ev_data;
        logic [174:0] last_req;
        s  = int'(addr[7:4]);
        t  = addr[31:8];
        w  = int'(addr[3:2]);
        ln = int'(addr[11:4]);
        hit = 0;
        way = 0;
        for (int k = 0; k < 2; k++)
            if (!hit && mv[s][k] && mt[s][k] == t) begin
                hit = 1;
                way = (k == 1);
            end
        if (!hit) way = pick_victim(s, t);
        exp_rf   = (typ != T_INIT) && !hit;
        exp_ev   = exp_rf && mv[s][way] && md[s][way];
        exp_test = hit && (typ != T_INIT);
        ev_addr  = {mt[s][way], addr[7:4], 4'h0};
        ev_data  = ref_mem[ev_addr[11:4]];
        exp_data = (typ == T_READ) ? ref_mem[ln][w*32 +: 32] : 32'h0;
        run_txn(typ, addr, wdata, opq, rs, ms, resp, lat);
        check("resp_msg", resp, {typ, opq, 1'b0, exp_test, 2'b00, exp_data});
        if (exp_test) check("hit_latency", lat, 3);
        nexp = int'(exp_ev) + int'(exp_rf);
        check("memreq_count", mrq_log.size(), nexp);
        if (mrq_log.size() == nexp && nexp > 0) begin
            if (exp_ev) check("evict_msg", mrq_log[0], {3'd1, 8'd0, ev_addr, 4'd0, ev_data});
            last_req = mrq_log[nexp-1];
            check("refill_hdr", last_req[174:128], {3'd0, 8'd0, t, addr[7:4], 4'h0, 4'h0});
        end
        if (!hit || typ == T_INIT) begin
            mv[s][way] = 1;
            mt[s][way] = t;
            md[s][way] = 0;
        end
        if (typ == T_WRITE) md[s][way] = 1;
        mlru[s] = ~way;
        if (typ != T_READ) ref_mem[ln][w*32 +: 32] = wdata;
    endtask

    initial begin
        logic [46:0]  r;
        logic [174:0] q;
        reset         = 1'b0;
        cachereq_val  = 1'b0;
        cachereq_msg  = '0;
        cacheresp_rdy = 1'b0;
        memreq_rdy    = 1'b0;
        memresp_val   = 1'b0;
        memresp_msg   = '0;
        for (int l = 0; l < 256; l++)
            for (int w = 0; w < 4; w++) begin
                mem[l][w*32 +: 32]     = 32'(4*l + w);
                ref_mem[l][w*32 +: 32] = 32'(4*l + w);
            end
        model_clear();

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_req_rdy", cachereq_rdy, 1'b0);
        check("rst_resp_val", cacheresp_val, 1'b0);
        check("rst_memreq_val", memreq_val, 1'b0);
        check("rst_memresp_rdy", memresp_rdy, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", cachereq_rdy, 1'b1);

        // Cold read miss, then a hit in the same line.
        do_op(T_READ, 32'h0000_0004, 32'h0, 8'h01, 0, 0, r);
        check("tp1_test", r[35:34], 2'd0);
        check("tp1_data", r[31:0], 32'h1);
        check("tp1_nreq", mrq_log.size(), 1);
        if (mrq_log.size() == 1) begin
            q = mrq_log[0];
            check("tp1_req_type", q[174:172], 3'd0);
            check("tp1_req_addr", q[163:132], 32'h0);
        end
        do_op(T_READ, 32'h0000_0008, 32'h0, 8'h02, 0, 0, r);
        check("tp1b_test", r[35:34], 2'd1);
        check("tp1b_data", r[31:0], 32'h2);
        check("tp1b_nreq", mrq_log.size(), 0);

        // Write allocate then read back.
        do_op(T_WRITE, 32'h0000_0010, 32'hDEAD_BEEF, 8'h5A, 0, 0, r);
        check("tp2_type", r[46:44], 3'd1);
        check("tp2_opaque", r[43:36], 8'h5A);
        check("tp2_data", r[31:0], 32'h0);
        do_op(T_READ, 32'h0000_0010, 32'h0, 8'h03, 0, 0, r);
        check("tp2b_data", r[31:0], 32'hDEAD_BEEF);
        check("tp2b_test", r[35:34], 2'd1);

        // Three lines in set 0: the third evicts the dirty line at 0x000.
        do_op(T_WRITE, 32'h0000_0000, 32'h0000_0011, 8'h04, 0, 0, r);
        do_op(T_READ,  32'h0000_0100, 32'h0, 8'h05, 0, 0, r);
        do_op(T_READ,  32'h0000_0200, 32'h0, 8'h06, 0, 0, r);
        check("tp3_data", r[31:0], 32'h80);
        check("tp3_nreq", mrq_log.size(), 2);
        if (mrq_log.size() == 2) begin
            q = mrq_log[0];
            check("tp3_ev_type", q[174:172], 3'd1);
            check("tp3_ev_addr", q[163:132], 32'h0);
            check("tp3_ev_word0", q[31:0], 32'h11);
            q = mrq_log[1];
            check("tp3_rf_type", q[174:172], 3'd0);
            check("tp3_rf_addr", q[163:132], 32'h0000_0200);
        end

        // INIT without memory traffic, then hit.
        do_op(T_INIT, 32'h0000_0040, 32'hCAFE_F00D, 8'h07, 0, 0, r);
        check("tp4_test", r[35:34], 2'd0);
        check("tp4_nreq", mrq_log.size(), 0);
        do_op(T_READ, 32'h0000_0040, 32'h0, 8'h08, 0, 0, r);
        check("tp4b_test", r[35:34], 2'd1);
        check("tp4b_data", r[31:0], 32'hCAFE_F00D);

        // Backpressure: stalled response on a hit, stalled memory on a miss.
        do_op(T_READ, 32'h0000_0104, 32'h0, 8'h09, 5, 0, r);
        check("tp5_data", r[31:0], 32'h41);
        do_op(T_READ, 32'h0000_0500, 32'h0, 8'h0A, 0, 4, r);
        check("tp5b_data", r[31:0], 32'h140);

        // Reset while waiting for a refill.
        @(negedge clk);
        cachereq_msg = {T_READ, 8'h33, 32'h0000_0300, 2'd0, 32'h0};
        cachereq_val = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cachereq_val = 1'b0;
        for (int i = 0; i < 20 && memreq_val !== 1'b1; i++) @(negedge clk);
        check("tp6_memreq", memreq_val, 1'b1);
        memreq_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        memreq_rdy = 1'b0;
        check("tp6_in_wait", memresp_rdy, 1'b1);
        reset = 1'b0;
        #1;
        check("tp6_resp_val", cacheresp_val, 1'b0);
        check("tp6_memreq_val", memreq_val, 1'b0);
        check("tp6_memresp_rdy", memresp_rdy, 1'b0);
        check("tp6_req_rdy", cachereq_rdy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        for (int l = 0; l < 256; l++) ref_mem[l] = mem[l];
        do_op(T_READ, 32'h0000_0300, 32'h0, 8'h0B, 0, 0, r);
        check("tp6b_test", r[35:34], 2'd0);
        check("tp6b_data", r[31:0], 32'hC0);

        // Random READ/WRITE traffic over 4 sets x 8 tags.
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  rt;
            logic [31:0] ra;
            rt = (($urandom_range(0, 1)) == 1) ? T_WRITE : T_READ;
            ra = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            do_op(rt, ra, $urandom, 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
